result_reader: RTL and testbench
================================

Name: result_reader

Overview:
- Host-side read-out stage sitting directly downstream of the engine's CPU memory read port (mem_rd_cpu_request / mem_rd_addr_cpu / mem_dout / mem_rd_cpu_valid).
- Accepts read commands (base address, word count, tag).
- Fetches that many consecutive MEM_WIDTH words from main memory, one outstanding read at a time.
- Streams the words out through a small first-word-fall-through (FWFT) FIFO with valid/ready handshake toward the output packet builder.

Parameters:
MEM_WIDTH, 64, width of a memory word and of out_data
ADDR_WIDTH, 12, memory address width; equals MEM_TOTAL_MSB+1
LEN_WIDTH, 5, width of cmd_len (max 31 words per command)
TAG_WIDTH, 8, width of the command tag echoed on output
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
RD_DELAY, 0, constant driven on rd_cpu_delay

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block accepts command (high only in IDLE)
cmd_addr  in  ADDR_WIDTH  first word address
cmd_len  in  LEN_WIDTH  number of words to read
cmd_tag  in  TAG_WIDTH  tag copied to every output word
mem_rd_cpu_request  out  1  one-cycle read request pulse
mem_rd_addr_cpu  out  ADDR_WIDTH  read address; stable from request until matching valid
rd_cpu_delay  out  MSB(MEM_CPU_RATIO-1)+1  constant RD_DELAY
mem_dout  in  MEM_WIDTH  memory read data
mem_rd_cpu_valid  in  1  mem_dout carries the word for the outstanding request
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pops on out_valid&&out_ready
out_data  out  MEM_WIDTH  head word
out_tag  out  TAG_WIDTH  tag of head word
out_last  out  1  head word is the final word of its command
busy  out  1  state != IDLE
err  out  1  sticky error flag

Behaviour:
- Reset (RST_N low, async): state IDLE, FIFO empty, all outputs 0 except cmd_ready=1. Reset mid-command abandons it; no partial data remains.
- FSM IDLE -> ISSUE -> WAIT -> (ISSUE | IDLE).
  - IDLE: cmd_ready=1. Handshake at cycle T latches addr/len/tag.
    - cmd_len=0: sets err, stays IDLE, no output.
    - Otherwise -> ISSUE at T+1.
  - ISSUE: if FIFO free slots (counting a pop in the same cycle) >= 1, pulse mem_rd_cpu_request for 1 cycle with current address, -> WAIT. Else hold in ISSUE, no request.
  - WAIT: on mem_rd_cpu_valid, push {mem_dout, tag, last} into the FIFO in that cycle; last = (remaining==1).
    - Address increments modulo 2^ADDR_WIDTH (0xFFF+1 wraps to 0x000).
    - Remaining decrements; if it becomes 0 -> IDLE (cmd_ready high the next cycle), else -> ISSUE.
- Minimum spacing between consecutive requests: 2 cycles after the valid (valid cycle, then ISSUE cycle).
- mem_rd_cpu_valid while not in WAIT: data dropped, err set.
- FIFO overflow cannot occur: a request is issued only with a reserved slot.
- FIFO push and pop in the same cycle are both honoured, including when the FIFO is full.
- FIFO is FWFT: a word pushed at cycle C is on out_data with out_valid=1 at C+1.
- out_data, out_tag, out_last are held stable while out_valid && !out_ready.
- err clears only on reset.

Optional Feature:
- Macro RESULT_READER_XOR_EN.
- When defined: after the last data word of a command, state CHK pushes one extra word = XOR of all words of that command (same tag).
  - out_last moves to this extra word; data words carry last=0.
  - CHK waits for a free FIFO slot, then returns to IDLE.
- When undefined: no CHK state, no accumulator, behaviour exactly as above.

Test Plan:
- Single command addr=0x010, len=3, tag=0x5A, memory latency 2, out_ready=1 -> requests at addresses 0x010, 0x011, 0x012; three outputs with tag 0x5A; out_last only on the third; cmd_ready returns 1 after the third valid.
- Backpressure: len=8, out_ready=0, FIFO_DEPTH=4 -> exactly 4 requests issued, then ISSUE holds. Raising out_ready drains all 8 words in order; no err.
- Wrap: addr=0xFFE, len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Errors: cmd_len=0 -> err=1, no request, cmd_ready stays 1. Stray mem_rd_cpu_valid in IDLE -> err=1, FIFO unchanged.
- Reset mid-command: assert RST_N low in WAIT of a len=5 command -> immediately out_valid=0, busy=0, err=0, mem_rd_cpu_request=0; a new command then completes normally.
- With RESULT_READER_XOR_EN: words 0x1, 0x2, 0x4 -> 4 outputs 0x1, 0x2, 0x4, 0x7; out_last on 0x7 only.

Source files
------------

// File: rtl/result_reader.sv
// Read-out stage: fetches cmd_len consecutive words from the CPU memory read port
// and streams them through a small FWFT FIFO. Define RESULT_READER_XOR_EN to append an XOR check word.
module result_reader #(
  parameter int MEM_WIDTH     = 64,
  parameter int ADDR_WIDTH    = 12,
  parameter int LEN_WIDTH     = 5,
  parameter int TAG_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int RD_DELAY      = 0,
  parameter int MEM_CPU_RATIO = 4,
  localparam int DLY_W = (MEM_CPU_RATIO > 2) ? $clog2(MEM_CPU_RATIO) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  mem_rd_cpu_request,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_cpu,
  output logic [DLY_W-1:0]      rd_cpu_delay,
  input  logic [MEM_WIDTH-1:0]  mem_dout,
  input  logic                  mem_rd_cpu_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MEM_WIDTH-1:0]  out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  typedef struct packed {
    logic [MEM_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0] tag;
    logic                 last;
  } entry_t;

`ifdef RESULT_READER_XOR_EN
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  err_q, err_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count;
  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                push_entry, head;
  logic                  push, pop, slot_free;
`ifdef RESULT_READER_XOR_EN
  logic [MEM_WIDTH-1:0]  acc_q, acc_d;
`endif

  assign count     = wr_ptr_q - rd_ptr_q;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees a slot, so a full FIFO being drained can still accept a request.
  assign slot_free = (count != DEPTH_C) || pop;
  assign head      = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign out_data  = out_valid ? head.data : '0;
  assign out_tag   = out_valid ? head.tag  : '0;
  assign out_last  = out_valid && head.last;

  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign err             = err_q;
  assign mem_rd_addr_cpu = addr_q;
  assign rd_cpu_delay    = DLY_W'(RD_DELAY);

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    rem_d              = rem_q;
    tag_d              = tag_q;
    err_d              = err_q;
    push               = 1'b0;
    push_entry         = '0;
    mem_rd_cpu_request = 1'b0;
`ifdef RESULT_READER_XOR_EN
    acc_d              = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          tag_d  = cmd_tag;
`ifdef RESULT_READER_XOR_EN
          acc_d  = '0;
`endif
          if (cmd_len == '0) err_d = 1'b1;
          else               state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (slot_free) begin
          mem_rd_cpu_request = 1'b1;
          state_d            = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rd_cpu_valid) begin
          push            = 1'b1;
          push_entry.data = mem_dout;
          push_entry.tag  = tag_q;
          addr_d          = addr_q + ADDR_WIDTH'(1);
          rem_d           = rem_q - LEN_WIDTH'(1);
`ifdef RESULT_READER_XOR_EN
          push_entry.last = 1'b0;
          acc_d           = acc_q ^ mem_dout;
          state_d         = (rem_q == LEN_WIDTH'(1)) ? S_CHK : S_ISSUE;
`else
          push_entry.last = (rem_q == LEN_WIDTH'(1));
          state_d         = (rem_q == LEN_WIDTH'(1)) ? S_IDLE : S_ISSUE;
`endif
        end
      end
`ifdef RESULT_READER_XOR_EN
      S_CHK: begin
        if (slot_free) begin
          push            = 1'b1;
          push_entry.data = acc_q;
          push_entry.tag  = tag_q;
          push_entry.last = 1'b1;
          state_d         = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Data arriving with no outstanding request is dropped.
    if (mem_rd_cpu_valid && state_q != S_WAIT) err_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef RESULT_READER_XOR_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef RESULT_READER_XOR_EN
      acc_q    <= acc_d;
`endif
    end
  end

  // Storage needs no reset: every output field is gated by out_valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
  end
endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: directed commands, memory responder, output monitor.
module tb_result_reader;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [11:0] cmd_addr = '0;
  logic [4:0]  cmd_len = '0;
  logic [7:0]  cmd_tag = '0;
  logic        mem_rd_cpu_request;
  logic [11:0] mem_rd_addr_cpu;
  logic [1:0]  rd_cpu_delay;
  logic [63:0] mem_dout;
  logic        mem_rd_cpu_valid;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_tag;
  logic        out_last, busy, err;

  logic        resp_v = 1'b0, stray_v = 1'b0;
  logic [63:0] resp_d = '0;
  assign mem_rd_cpu_valid = resp_v | stray_v;
  assign mem_dout         = resp_d;

  result_reader dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
    .mem_rd_cpu_request(mem_rd_cpu_request), .mem_rd_addr_cpu(mem_rd_addr_cpu),
    .rd_cpu_delay(rd_cpu_delay), .mem_dout(mem_dout), .mem_rd_cpu_valid(mem_rd_cpu_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0, n_err = 0, n_req = 0, gen = 0, lat = 2;
  logic [63:0] mem_arr [4096];
  logic [72:0] exp_q [$];
  logic [11:0] exp_addr [$];

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Memory model: answers each request after lat cycles unless a reset intervened.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && mem_rd_cpu_request) begin
        automatic logic [11:0] a = mem_rd_addr_cpu;
        automatic int g = gen;
        n_req++;
        if (exp_addr.size() == 0) check("unexpected_request", {84'h0, a}, 96'hFFF_FFFF);
        else check("req_addr", {84'h0, a}, {84'h0, exp_addr.pop_front()});
        repeat (lat) @(posedge CLK);
        #1;
        if (g == gen) begin
          resp_v = 1'b1;
          resp_d = mem_arr[a];
          @(posedge CLK);
          #1 resp_v = 1'b0;
        end
      end
    end
  end

  // Output monitor: pops scoreboard on each transfer; checks hold stability under stall.
  initial begin
    automatic logic        held = 1'b0;
    automatic logic [72:0] prev = '0;
    forever begin
      @(negedge CLK);
      if (RST_N && out_valid) begin
        if (held) check("hold_stable", {23'h0, out_data, out_tag, out_last}, {23'h0, prev});
        if (out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) check("unexpected_output", {23'h0, out_data, out_tag, out_last}, '1);
          else check("out_word", {23'h0, out_data, out_tag, out_last}, {23'h0, exp_q.pop_front()});
        end else begin
          held = 1'b1;
          prev = {out_data, out_tag, out_last};
        end
      end else held = 1'b0;
    end
  end

  task automatic send(input logic [11:0] a, input logic [4:0] n, input logic [7:0] t);
    logic [63:0] x;
    x = '0;
    for (int i = 0; i < int'(n); i++) begin
      automatic logic [11:0] ai = a + 12'(i);
      exp_addr.push_back(ai);
      x ^= mem_arr[ai];
`ifdef RESULT_READER_XOR_EN
      exp_q.push_back({mem_arr[ai], t, 1'b0});
`else
      exp_q.push_back({mem_arr[ai], t, (i == int'(n) - 1)});
`endif
    end
`ifdef RESULT_READER_XOR_EN
    if (n != 0) exp_q.push_back({x, t, 1'b1});
`endif
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = n; cmd_tag = t;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge CLK);
      #2;
      if (!busy && !out_valid && exp_q.size() == 0) done = 1'b1;
    end
    check(nm, {95'h0, done}, 96'h1);
    check({nm, "_addr_q_empty"}, 96'(exp_addr.size()), 96'h0);
  endtask

  task automatic do_reset();
    #2 RST_N = 1'b0;
    gen++;
    exp_q.delete();
    exp_addr.delete();
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic seen;
    for (int i = 0; i < 4096; i++) begin
      automatic logic [11:0] ai = 12'(i);
      mem_arr[i] = {20'hABCDE, ai, 20'h12345, ~ai};
    end
    mem_arr[12'h100] = 64'h1; mem_arr[12'h101] = 64'h2; mem_arr[12'h102] = 64'h4;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_cmd_ready", 96'(cmd_ready), 96'h1);
    check("rst_out_valid", 96'(out_valid), 96'h0);
    check("rst_busy", 96'(busy), 96'h0);
    check("rst_err", 96'(err), 96'h0);
    check("rst_request", 96'(mem_rd_cpu_request), 96'h0);
    check("rst_out_data", 96'(out_data), 96'h0);
    check("rd_cpu_delay", 96'(rd_cpu_delay), 96'h0);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    // Single command, latency 2; cmd_ready must return right after the third valid.
    lat = 2;
    send(12'h010, 5'd3, 8'h5A);
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge CLK);
        if (mem_rd_cpu_valid) seen = 1'b1;
      end
      check("valid_seen", 96'(seen), 96'h1);
    end
`ifdef RESULT_READER_XOR_EN
    @(posedge CLK);
`endif
    @(posedge CLK);
    #1 check("t1_cmd_ready", 96'(cmd_ready), 96'h1);
    wait_idle("t1_done");
    check("t1_err", 96'(err), 96'h0);

    // Backpressure: only FIFO_DEPTH requests may go out while the consumer stalls.
    out_ready = 1'b0;
    base = n_req;
    send(12'h200, 5'd8, 8'h33);
    repeat (40) @(posedge CLK);
    #1;
    check("bp_req_count", 96'(n_req - base), 96'h4);
    check("bp_busy", 96'(busy), 96'h1);
    check("bp_out_valid", 96'(out_valid), 96'h1);
    check("bp_no_request", 96'(mem_rd_cpu_request), 96'h0);
    for (int c = 0; c < 30; c++) begin
      out_ready = (c % 3 != 0);
      @(posedge CLK);
      #1;
    end
    out_ready = 1'b1;
    wait_idle("bp_done");
    check("bp_req_total", 96'(n_req - base), 96'h8);
    check("bp_err", 96'(err), 96'h0);

    // Address wrap at the top of memory.
    lat = 3;
    send(12'hFFE, 5'd4, 8'hC3);
    wait_idle("wrap_done");

    // Words 1,2,4 (XOR build appends 7).
    lat = 1;
    send(12'h100, 5'd3, 8'h11);
    wait_idle("xor_done");
    check("xor_err", 96'(err), 96'h0);

    // Zero-length command.
    lat = 2;
    base = n_req;
    cmd_valid = 1'b1; cmd_addr = 12'h050; cmd_len = 5'd0; cmd_tag = 8'h99;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("len0_err", 96'(err), 96'h1);
    check("len0_cmd_ready", 96'(cmd_ready), 96'h1);
    check("len0_no_req", 96'(n_req - base), 96'h0);
    check("len0_out_valid", 96'(out_valid), 96'h0);
    do_reset();
    check("err_cleared", 96'(err), 96'h0);

    // Stray valid in IDLE.
    stray_v = 1'b1; resp_d = 64'hDEAD;
    @(posedge CLK);
    #1 stray_v = 1'b0;
    check("stray_err", 96'(err), 96'h1);
    check("stray_out_valid", 96'(out_valid), 96'h0);
    do_reset();

    // Reset during WAIT of a len=5 command, then a clean command.
    base = n_req;
    send(12'h300, 5'd5, 8'h77);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (n_req != base) seen = 1'b1;
    end
    check("mid_req_seen", 96'(seen), 96'h1);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    gen++;
    exp_q.delete();
    exp_addr.delete();
    #1;
    check("mid_out_valid", 96'(out_valid), 96'h0);
    check("mid_busy", 96'(busy), 96'h0);
    check("mid_err", 96'(err), 96'h0);
    check("mid_request", 96'(mem_rd_cpu_request), 96'h0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    send(12'h040, 5'd2, 8'h21);
    wait_idle("post_rst_done");
    check("post_rst_err", 96'(err), 96'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
